// File: rtl/rca32_addsub.sv
// rca32_addsub: ripple-carry adder/subtractor with registered outputs.
// Computes a+b (sub=0) or a-b (sub=1) in two's complement. Results appear one
// clock after the operands are sampled, at a rate of one operation per cycle.
// c32 is the carry out of the top stage. In subtract mode it is the not-borrow
// flag. of is the signed overflow flag.
// Optional build macro RCA32_ZERO_FLAG_EN adds output z. z is a registered
// flag that is set when the result is all zeros.
module rca32_addsub #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] s,
    output logic             c32,
    output logic             of
`ifdef RCA32_ZERO_FLAG_EN
    ,
    output logic             z
`endif
);

    // One full-adder stage: sum bit.
    function automatic logic fa_sum(input logic x, input logic y, input logic ci);
        return x ^ y ^ ci;
    endfunction

    // One full-adder stage: carry to the next stage.
    function automatic logic fa_carry(input logic x, input logic y, input logic ci);
        return (x & y) | (ci & (x ^ y));
    endfunction

    logic [WIDTH-1:0] b_x_s;      // b, inverted when subtracting
    logic [WIDTH:0]   carry_s;    // carry_s[i] is the carry into stage i
    logic [WIDTH-1:0] sum_s;
    logic             of_s;

    logic [WIDTH-1:0] s_r;
    logic             c32_r;
    logic             of_r;

    // Ripple the carry through the adder chain, one stage at a time (no lookahead).
    always_comb begin
        b_x_s      = b ^ {WIDTH{sub}};
        carry_s    = {(WIDTH+1){1'b0}};
        sum_s      = {WIDTH{1'b0}};
        carry_s[0] = sub;
        for (int i = 0; i < WIDTH; i++) begin
            sum_s[i]       = fa_sum(a[i], b_x_s[i], carry_s[i]);
            carry_s[i + 1] = fa_carry(a[i], b_x_s[i], carry_s[i]);
        end
        // Overflow is detected from the inverted operand b', not from the raw b.
        of_s = (a[WIDTH-1] == b_x_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
    end

    // Capture result and flags every cycle; reset takes priority and discards the operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_r   <= {WIDTH{1'b0}};
            c32_r <= 1'b0;
            of_r  <= 1'b0;
        end else begin
            s_r   <= sum_s;
            c32_r <= carry_s[WIDTH];
            of_r  <= of_s;
        end
    end

    assign s   = s_r;
    assign c32 = c32_r;
    assign of  = of_r;

`ifdef RCA32_ZERO_FLAG_EN
    logic z_r;

    // Register the zero flag in step with the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            z_r <= 1'b0;
        end else begin
            z_r <= (sum_s == {WIDTH{1'b0}});
        end
    end

    assign z = z_r;
`endif

endmodule

// File: tb/tb_rca32_addsub.sv
// Bench for rca32_addsub: directed vector table, mid-stream reset sequence,
// and random vectors checked against a (WIDTH+1)-bit reference sum.
module tb_rca32_addsub;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] s;
    logic        c32;
    logic        of;
`ifdef RCA32_ZERO_FLAG_EN
    logic        z;
`endif

    int tests;
    int fails;

    rca32_addsub #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .sub (sub),
        .s   (s),
        .c32 (c32),
        .of  (of)
`ifdef RCA32_ZERO_FLAG_EN
        ,
        .z   (z)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] exp_s;
        logic        exp_c;
        logic        exp_of;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [31:0] es, input logic ec, input logic eo);
        check({name, ".s"}, s, es);
        check({name, ".c32"}, {31'd0, c32}, {31'd0, ec});
        check({name, ".of"}, {31'd0, of}, {31'd0, eo});
`ifdef RCA32_ZERO_FLAG_EN
        check({name, ".z"}, {31'd0, z}, {31'd0, (es == 32'd0)});
`endif
    endtask

    initial begin
        logic [32:0] ref_sum;
        logic [31:0] bx;
        logic        ref_of;

        tests = 0;
        fails = 0;

        vecs[0]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[1]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[2]  = '{32'hAAAAAAAA, 32'h55555555, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[3]  = '{32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[5]  = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[6]  = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h80000000, 1'b0, 1'b1};
        vecs[7]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[8]  = '{32'h00000005, 32'h00000003, 1'b1, 32'h00000002, 1'b1, 1'b0};
        vecs[9]  = '{32'h00000003, 32'h00000005, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[10] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[11] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[12] = '{32'h80000000, 32'h80000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[13] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, 1'b0};

        // Reset with non-zero operands present: reset must win.
        rst = 1'b1;
        a   = 32'hFFFFFFFF;
        b   = 32'h00000001;
        sub = 1'b0;
        @(posedge clk);
        #1;
        check_outs("reset", 32'd0, 1'b0, 1'b0);

        // Directed table, one vector per cycle (back-to-back, no bubbles).
        rst = 1'b0;
        for (int i = 0; i < 14; i++) begin
            a   = vecs[i].a;
            b   = vecs[i].b;
            sub = vecs[i].sub;
            @(posedge clk);
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].exp_s, vecs[i].exp_c, vecs[i].exp_of);
        end

        // Mid-stream reset: the operation sampled with rst=1 is discarded.
        a   = 32'h80000000;
        b   = 32'h80000000;
        sub = 1'b0;
        @(posedge clk);
        #1;
        check_outs("pre_rst", 32'h00000000, 1'b1, 1'b1);
        rst = 1'b1;
        a   = 32'h7FFFFFFF;
        b   = 32'h00000001;
        @(posedge clk);
        #1;
        check_outs("mid_rst", 32'd0, 1'b0, 1'b0);
        rst = 1'b0;
        a   = 32'h00000000;
        b   = 32'h00000001;
        sub = 1'b1;
        @(posedge clk);
        #1;
        check_outs("post_rst", 32'hFFFFFFFF, 1'b0, 1'b0);

        // Random vectors against a (WIDTH+1)-bit reference sum.
        for (int i = 0; i < 250; i++) begin
            a   = $urandom;
            b   = $urandom;
            sub = 1'($urandom_range(1, 0));
            bx      = sub ? ~b : b;
            ref_sum = {1'b0, a} + {1'b0, bx} + {32'd0, sub};
            ref_of  = (a[31] == bx[31]) && (ref_sum[31] != a[31]);
            @(posedge clk);
            #1;
            check_outs($sformatf("rand%0d", i), ref_sum[31:0], ref_sum[32], ref_of);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rca32_addsub.md
Name: rca32_addsub

Overview:
- 32-bit ripple-carry adder/subtractor with registered outputs, used as the add/sub datapath of the ALU.
- Computes a+b or a-b in two's complement and reports unsigned carry-out and signed overflow.
- One clock, synchronous active-high reset; results appear one cycle after the operands are sampled.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2). Port names c32/of keep their meaning for any WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  0 = add (a+b), 1 = subtract (a-b)
- s  output  WIDTH  registered result, low WIDTH bits
- c32  output  1  registered carry-out of the MSB stage
- of  output  1  registered signed-overflow flag

Behaviour:
- Reset: on a rising clk with rst=1, s=0, c32=0 and of=0. Reset has priority over the operand inputs; an operation in flight is discarded.
- Datapath (combinational):
  - b' = b XOR {WIDTH{sub}}.
  - Carry-in c0 = sub.
  - Explicit chain of WIDTH full adders: s_i = a_i ^ b'_i ^ c_i; c_{i+1} = a_i&b'_i | c_i&(a_i^b'_i).
  - The carry chain must ripple bit to bit; no carry-lookahead and no behavioural "+" on the full width.
- Result width:
  - {c32, s} = {0,a} + {0,b'} + sub, taken as a (WIDTH+1)-bit sum with no truncation error.
  - c32 = c_WIDTH.
  - In subtract mode, c32 is the not-borrow flag: c32=1 iff a >= b unsigned.
- Overflow: of = (a[MSB] == b'[MSB]) && (s[MSB] != a[MSB]), which is equivalent to c_WIDTH ^ c_{WIDTH-1}. It uses b', not b.
- Latency:
  - Every rising clk with rst=0 registers s, c32 and of from the current a, b, sub.
  - Outputs reflect the inputs sampled one edge earlier, so throughput is one operation per cycle.
  - No valid/ready handshake; there are no enable or stall inputs.
- Wrap-around: results are modulo 2^WIDTH. For example, 0xFFFFFFFF+1 gives s=0, c32=1, of=0.
- Simultaneous events: a change of sub and the operands in the same cycle is a single operation; there is no hazard between them.
- X/undriven inputs need not be handled specially.

Optional Feature:
- Macro: RCA32_ZERO_FLAG_EN
- Defined:
  - Adds output port z (1 bit), registered alongside s.
  - z=1 iff the next s value is all zeros.
  - z resets to 0.
- Undefined: port z does not exist; all other behaviour is identical.

Test Plan:
- Reset, then overflow add: with rst=1 for 1 edge, s=0, c32=0, of=0. Then rst=0, sub=0, a=0x7FFFFFFF, b=0x00000001. One edge later: s=0x80000000, c32=0, of=1.
- Min+min: sub=0, a=0x80000000, b=0x80000000 gives s=0x00000000, c32=1, of=1 (z=1 if enabled). Also sub=0, a=0xAAAAAAAA, b=0x55555555 gives s=0xFFFFFFFF, c32=0, of=0.
- Borrow: sub=1, a=0, b=1 gives s=0xFFFFFFFF, c32=0, of=0. Also sub=1, a=0xFFFFFFFF, b=0xFFFFFFFF gives s=0, c32=1, of=0.
- Overflow subtract: sub=1, a=0x80000000, b=1 gives s=0x7FFFFFFF, c32=1, of=1. Also sub=1, a=0x7FFFFFFF, b=0xFFFFFFFF gives s=0x80000000, c32=0, of=1.
- Back-to-back and mid-stream reset:
  - Apply a new vector every cycle; each result appears exactly 1 edge later with no bubbles.
  - Asserting rst mid-stream zeroes all outputs on that edge.
- Random: at least 200 random {a, b, sub} vectors. Compare s, c32 and of one cycle later against the (WIDTH+1)-bit reference sum and the overflow formula above, with zero mismatches.
